// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer.
package pc_ctrl_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: jr (when PC_JR_EN) > jump > taken branch > pc+4.
module pc_next_sel
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
`ifdef PC_JR_EN
  input  logic        jr,
  input  logic [31:0] jr_addr,
`endif
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  // Offsets are word counts; all sums wrap modulo 2^32.
  assign pc4       = instr_pc + WORD_BYTES;
  assign br_target = pc4 + {branch_offset[29:0], 2'b00};
  assign j_target  = {pc4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc4;
`ifdef PC_JR_EN
    if (jr)
      next_pc = jr_addr & 32'hFFFF_FFFC;
    else if (jump)
      next_pc = j_target;
    else if (branch && zero)
      next_pc = br_target;
`else
    if (jump)
      next_pc = j_target;
    else if (branch && zero)
      next_pc = br_target;
`endif
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem handshake and holds each instruction until consumed.
// Optional register-indirect jump (jr/jr_addr ports) is enabled by defining PC_JR_EN.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
`ifdef PC_JR_EN
  input  logic        jr,
  input  logic [31:0] jr_addr,
`endif
  output logic [31:0] pc,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  next_pc;
  logic         consume;

  pc_next_sel u_next_sel (
    .instr_pc      (instr_pc_q),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
`ifdef PC_JR_EN
    .jr            (jr),
    .jr_addr       (jr_addr),
`endif
    .next_pc       (next_pc)
  );

  assign consume = (state_q == HOLD) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (consume) begin
          pc_d          = next_pc;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Request is masked during reset so an in-flight access is visibly abandoned.
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, branch/jump select, stall, reset mid-fetch.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
`ifdef PC_JR_EN
  logic        jr;
  logic [31:0] jr_addr;
`endif
  logic [31:0] pc;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_count = 32'h0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
`ifdef PC_JR_EN
    .jr            (jr),
    .jr_addr       (jr_addr),
`endif
    .pc            (pc),
    .fetch_count   (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch = 1'b0; zero = 1'b0; branch_offset = 32'h0; jump = 1'b0; jump_index = 26'h0;
`ifdef PC_JR_EN
    jr = 1'b0; jr_addr = 32'h0;
`endif
  endtask

  // Fetch at the expected address, then consume with whatever redirect inputs the caller set.
  task automatic fetch_and_consume(input string nm, input logic [31:0] addr, input logic [31:0] word,
                                   input logic [31:0] exp_next);
    checks++; if (imem_req !== 1'b1 || imem_addr !== addr) begin errors++;
      $display("FAIL %s_req got req=%b addr=%h exp req=1 addr=%h", nm, imem_req, imem_addr, addr); end
    imem_ready = 1'b1; imem_rdata = word; stall = 1'b0;
    step();
    imem_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== word || instr_pc !== addr || imem_req !== 1'b0) begin errors++;
      $display("FAIL %s_hold got v=%b instr=%h ipc=%h req=%b exp v=1 instr=%h ipc=%h req=0",
               nm, instr_valid, instr, instr_pc, imem_req, word, addr); end
    step();
    exp_count++;
    clear_redirects();
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_next || fetch_count !== exp_count) begin errors++;
      $display("FAIL %s_next got req=%b addr=%h cnt=%0d exp req=1 addr=%h cnt=%0d",
               nm, imem_req, imem_addr, fetch_count, exp_next, exp_count); end
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    clear_redirects();
    #3;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 ||
                  instr_pc !== 32'h0 || fetch_count !== 32'h0) begin errors++;
      $display("FAIL reset_vals got req=%b v=%b pc=%h instr=%h ipc=%h cnt=%0d exp all zero",
               imem_req, instr_valid, pc, instr, instr_pc, fetch_count); end
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
      $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    fetch_and_consume("seq0", 32'h0, 32'hC0DE_0000, 32'h4);
    fetch_and_consume("seq1", 32'h4, 32'hC0DE_0001, 32'h8);
    fetch_and_consume("seq2", 32'h8, 32'hC0DE_0002, 32'hC);
    checks++; if (fetch_count !== 32'd3) begin errors++;
      $display("FAIL seq_count got %0d exp 3", fetch_count); end
  endtask

  task automatic test_branch();
    jump = 1'b1; jump_index = 26'h10;
    fetch_and_consume("jmp_to_40", 32'hC, 32'h0800_0010, 32'h40);
    branch = 1'b1; zero = 1'b1; branch_offset = 32'hFFFF_FFFE;
    fetch_and_consume("br_back", 32'h40, 32'h1000_FFFE, 32'h3C);
    branch = 1'b1; zero = 1'b1; branch_offset = 32'h0;
    fetch_and_consume("br_zero_off", 32'h3C, 32'h1000_0000, 32'h40);
    branch = 1'b1; zero = 1'b0; branch_offset = 32'hFFFF_FFFE;
    fetch_and_consume("br_not_taken", 32'h40, 32'h1000_FFFE, 32'h44);
  endtask

  task automatic test_jump_priority();
    branch = 1'b1; zero = 1'b1; branch_offset = 32'h03FF_FFF2;
    fetch_and_consume("br_far", 32'h44, 32'h1000_FFF2, 32'h1000_0010);
    jump = 1'b1; jump_index = 26'h000_0100; branch = 1'b1; zero = 1'b1; branch_offset = 32'h5;
    fetch_and_consume("jmp_prio", 32'h1000_0010, 32'h0800_0100, 32'h1000_0400);
  endtask

  task automatic test_wrap();
    branch = 1'b1; zero = 1'b1; branch_offset = 32'h3BFF_FEFE;
    fetch_and_consume("br_to_top", 32'h1000_0400, 32'h1000_FEFE, 32'hFFFF_FFFC);
    fetch_and_consume("pc_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 32'h0);
  endtask

  task automatic test_stall();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
      $display("FAIL stall_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b1;
    step();
    // Garbage on the handshake and redirect inputs must be ignored while held.
    imem_rdata = 32'h1234_5678; jump = 1'b1; jump_index = 26'h3FF_FFFF; branch = 1'b1; zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF || instr_pc !== 32'h0 ||
                    imem_req !== 1'b0 || fetch_count !== exp_count) begin errors++;
        $display("FAIL stall_hold%0d got v=%b instr=%h ipc=%h req=%b cnt=%0d exp v=1 instr=deadbeef ipc=0 req=0 cnt=%0d",
                 i, instr_valid, instr, instr_pc, imem_req, fetch_count, exp_count); end
      step();
    end
    imem_ready = 1'b0; clear_redirects(); stall = 1'b0;
    step();
    exp_count++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fetch_count !== exp_count) begin errors++;
      $display("FAIL stall_release got req=%b addr=%h cnt=%0d exp req=1 addr=4 cnt=%0d",
               imem_req, imem_addr, fetch_count, exp_count); end
    step();
    checks++; if (imem_req !== 1'b1 || fetch_count !== exp_count) begin errors++;
      $display("FAIL stall_once got req=%b cnt=%0d exp req=1 cnt=%0d", imem_req, fetch_count, exp_count); end
  endtask

  task automatic test_reset_mid_fetch();
    imem_ready = 1'b0;
    step(); step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL wait_req got req=%b addr=%h v=%b exp req=1 addr=4 v=0", imem_req, imem_addr, instr_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 ||
                  instr_pc !== 32'h0 || fetch_count !== 32'h0) begin errors++;
      $display("FAIL async_reset got req=%b v=%b pc=%h instr=%h ipc=%h cnt=%0d exp all zero",
               imem_req, instr_valid, pc, instr, instr_pc, fetch_count); end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ready = 1'b0;
    reset = 1'b0;
    exp_count = 32'h0;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++;
      $display("FAIL reset_no_capture got v=%b instr=%h exp v=0 instr=0", instr_valid, instr); end
    fetch_and_consume("restart", 32'h0, 32'h2400_0001, 32'h4);
  endtask

`ifdef PC_JR_EN
  task automatic test_jr();
    jr = 1'b1; jr_addr = 32'h0000_1237; jump = 1'b1; jump_index = 26'h3FF_0000;
    fetch_and_consume("jr_prio", 32'h4, 32'h00E0_0008, 32'h0000_1234);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_stall();
    test_reset_mid_fetch();
`ifdef PC_JR_EN
    test_jr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the MIPS core. It owns the program counter and drives the instruction-memory request/ready handshake. It holds each fetched instruction until the downstream stage consumes it, then selects the next PC: sequential PC+4, a taken branch (branch & zero), or a jump. It sits between instruction memory and decode, and replaces the free-running PC register and the stand-alone next-PC select.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc while imem_req=1
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  32  held instruction
- instr_pc  out  32  address of held instruction
- stall  in  1  downstream not accepting; instruction consumed when instr_valid & !stall
- branch  in  1  consumed instruction is a conditional branch
- zero  in  1  ALU zero for that branch
- branch_offset  in  32  sign-extended 16-bit immediate (word offset)
- jump  in  1  consumed instruction is J/JAL
- jump_index  in  26  J-format target field
- pc  out  32  current fetch PC
- fetch_count  out  32  number of instructions consumed since reset

## Operation
- FSM states: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, instr_pc<=pc, go to HOLD.
- HOLD: instr_valid=1, imem_req=0. On !stall the instruction is consumed:
  - pc<=next_pc
  - fetch_count increments
  - go to FETCH
- While stall=1, the HOLD contents are frozen.
- next_pc, in priority order:
  - jump: {pc4[31:28], jump_index, 2'b00}
  - else branch & zero: pc4 + (branch_offset << 2)
  - else pc4
  - pc4 = instr_pc + 4.
- branch, zero, branch_offset, jump and jump_index are sampled only in the consume cycle. They are don't-care otherwise.
- Arithmetic is 32-bit modulo 2^32. PC wrap 32'hFFFF_FFFC -> 0 is legal. fetch_count wraps to 0.
- branch=1, zero=0 is not taken and gives pc4.

## Timing
- Reset (async, any state): state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0.
- imem_req=1 in the first cycle after reset deasserts.
- Latency:
  - imem_ready in cycle N gives instr_valid=1 in cycle N+1.
  - Consume in cycle M gives imem_req=1 with the new address in cycle M+1.
- Throughput: at most one instruction per 2 cycles with zero-wait memory.
- imem_ready is ignored outside FETCH.
- The memory must tolerate imem_req dropping mid-access on reset. A response arriving after reset is not captured unless the new FETCH is active.
- Simultaneous jump and branch&zero: jump wins.

## Configuration
- PC_JR_EN defined:
  - Adds ports jr (in, 1) and jr_addr (in, 32).
  - On consume with jr=1: next_pc = {jr_addr[31:2], 2'b00}.
  - Priority is jr > jump > branch.
- PC_JR_EN undefined: the ports are absent and behaviour is as above.

## Structure
- Package pc_ctrl_pkg:
  - fetch-state enum (FETCH, HOLD)
  - WORD_BYTES=4
  - default RESET_PC constant
- One sub-module, pc_next_sel: the combinational next-PC priority select, including the PC_JR_EN branch. The FSM and registers stay in pc_fetch_ctrl.

## Test plan
- Reset, imem_ready=1 every FETCH cycle, no redirects, stall=0 -> imem_addr 0x0, 0x4, 0x8 on alternating cycles; fetch_count=3 after three consumes.
- Instruction at 0x40 consumed with branch=1, zero=1, branch_offset=32'hFFFF_FFFE -> next imem_addr=0x3C. Same with zero=0 -> 0x44.
- Instruction at 0x1000_0010, jump=1, jump_index=26'h000_0100, branch=1, zero=1 -> next imem_addr=0x1000_0400 (jump priority).
- stall=1 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, fetch_count unchanged; stall=0 -> advance once.
- imem_ready held low 4 cycles in FETCH, reset pulsed mid-wait -> all outputs at reset values immediately; fetch restarts at RESET_PC.
- With PC_JR_EN, jr=1, jr_addr=0x0000_1237, jump=1 -> next imem_addr=0x0000_1234.
